// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit 74181-style ALU slice between NUM_REQ
// requesters: grant, drive and hold operands, sample y after ALU_LAT cycles, return result.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_s,
  input  logic [NUM_REQ-1:0]   req_ci,
  input  logic [NUM_REQ-1:0]   req_m,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [3:0]           rsp_y,
  output logic [3:0]           alu_s,
  output logic                 alu_ci,
  output logic                 alu_m,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  input  logic [3:0]           alu_y
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3:0]         alu_s_q, alu_s_d;
  logic               alu_ci_q, alu_ci_d;
  logic               alu_m_q, alu_m_d;
  logic [3:0]         alu_a_q, alu_a_d;
  logic [3:0]         alu_b_q, alu_b_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [3:0]         rsp_y_q, rsp_y_d;

  logic               gnt_found;
  logic [IdxW-1:0]    gnt_idx;
  logic [IdxW-1:0]    scan_idx;
  logic               accept;

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == StIdle) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    alu_s_d     = alu_s_q;
    alu_ci_d    = alu_ci_q;
    alu_m_d     = alu_m_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(gnt_idx) == i) begin
              alu_s_d  = req_s[4*i +: 4];
              alu_ci_d = req_ci[i];
              alu_m_d  = req_m[i];
              alu_a_d  = req_a[4*i +: 4];
              alu_b_d  = req_b[4*i +: 4];
            end
          end
          owner_d  = gnt_idx;
          rr_ptr_d = IdxW'((32'(gnt_idx) + 1) % NUM_REQ);
          cnt_d    = 3'(ALU_LAT);
          state_d  = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 3'd1) begin
          rsp_y_d              = alu_y;
          rsp_valid_d          = '0;
          rsp_valid_d[owner_q] = 1'b1;
          cnt_d                = 3'd0;
          state_d              = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= 3'd0;
      alu_s_q     <= 4'd0;
      alu_ci_q    <= 1'b0;
      alu_m_q     <= 1'b0;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      rsp_valid_q <= '0;
      rsp_y_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      alu_s_q     <= alu_s_d;
      alu_ci_q    <= alu_ci_d;
      alu_m_q     <= alu_m_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign alu_s     = alu_s_q;
  assign alu_ci    = alu_ci_q;
  assign alu_m     = alu_m_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;

endmodule
